// File: rtl/xor_parity_pkg.sv
// Shared types and constants for the XOR parity transmit/receive path.
package xor_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/xor_parity_acc.sv
// 1-bit running XOR accumulator with synchronous clear and enable.
// Shared between the transmit-side generator and the receive-side checker.
module xor_parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

// File: rtl/xor_parity_rx.sv
// Serial start/data/parity/stop frame receiver with parity/framing checks,
// overrun detection and a valid/ready output register.
module xor_parity_rx
    import xor_parity_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit PARITY_ODD = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shift_q;
    logic               acc_q;
    logic               acc_clr;
    logic               acc_en;
    logic               perr_q;
    logic               ferr_q;
    logic               frame_done;
    logic               handshake;
    logic               load;

    xor_parity_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .d   (rx_bit),
        .q   (acc_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        if (sample_en) begin
            unique case (state)
                IDLE: begin
                    if (!rx_bit) begin
                        state_nxt = DATA;
                        acc_clr   = 1'b1;
                    end
                end
                DATA: begin
                    acc_en = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A 0 stop bit only flags a framing error; the FSM still returns to IDLE and waits for a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (sample_en) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_bit) begin
                            cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_q[cnt] <= rx_bit;
                        cnt          <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                    end
                    PARITY: begin
                        perr_q <= acc_q ^ rx_bit ^ PARITY_ODD;
                    end
                    STOP: begin
                        ferr_q     <= ~rx_bit;
                        frame_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign handshake = data_valid & data_ready;
    assign load      = frame_done & (~data_valid | data_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                data_out   <= shift_q;
                parity_err <= perr_q;
                frame_err  <= ferr_q;
                data_valid <= 1'b1;
            end else if (handshake) begin
                data_valid <= 1'b0;
            end

            if (frame_done && !load) begin
                overrun <= 1'b1;
            end else if (handshake) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_xor_parity_rx.sv
// Self-checking bench for xor_parity_rx: directed frame scenarios plus a randomized
// frame stream scored against a frame-level reference queue.
module tb_xor_parity_rx;
    import xor_parity_pkg::*;

    localparam int W   = 8;
    localparam bit ODD = PAR_EVEN;

    typedef struct {
        logic [W-1:0] data;
        logic         perr;
        logic         ferr;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sample_en;
    logic         rx_bit;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int     n_checks = 0;
    int     n_pass   = 0;
    bit     sb_on    = 1'b0;
    frame_t exp_q[$];
    frame_t mon_e;

    logic [W-1:0] r_data;
    logic         r_par;
    logic         r_stop;
    int           r_gap;
    int           r_idle;

    xor_parity_rx #(
        .DATA_W     (W),
        .PARITY_ODD (ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .rx_bit     (rx_bit),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Parity error: total ones over data+parity disagrees with the configured sense.
    function automatic logic exp_perr(input logic [W-1:0] d, input logic par);
        return ((($countones(d) + int'(par)) % 2) != int'(ODD));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            sample_en = 1'b0;
            tick();
        end
        sample_en = 1'b1;
        rx_bit    = b;
        tick();
        sample_en = 1'b0;
        rx_bit    = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stop, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) begin
            send_bit(d[i], gap);
        end
        send_bit(par, gap);
        send_bit(stop, gap);
    endtask

    task automatic consume(input string tag);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check({tag, "_valid_drop"}, data_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},    data_out,   0);
        check({tag, "_valid"},   data_valid, 0);
        check({tag, "_perr"},    parity_err, 0);
        check({tag, "_ferr"},    frame_err,  0);
        check({tag, "_overrun"}, overrun,    0);
        check({tag, "_busy"},    busy,       0);
    endtask

    always @(negedge clk) begin
        if (sb_on && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_data", data_out,   mon_e.data);
                check("sb_perr", parity_err, mon_e.perr);
                check("sb_ferr", frame_err,  mon_e.ferr);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        sample_en  = 1'b0;
        rx_bit     = 1'b1;
        data_ready = 1'b0;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: clean frame
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        check("t1_latency", data_valid, 0);
        tick();
        check("t1_valid", data_valid, 1);
        check("t1_data",  data_out,   8'hA5);
        check("t1_perr",  parity_err, exp_perr(8'hA5, 1'b0));
        check("t1_ferr",  frame_err,  0);
        consume("t1");

        // 2: parity error still delivered
        send_frame(8'h07, 1'b0, 1'b1, 0);
        tick();
        check("t2_valid", data_valid, 1);
        check("t2_data",  data_out,   8'h07);
        check("t2_perr",  parity_err, 1);
        check("t2_ferr",  frame_err,  0);
        consume("t2");

        // 3: framing error, FSM returns to IDLE
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        check("t3_busy", busy, 0);
        tick();
        check("t3_data", data_out,  8'h3C);
        check("t3_ferr", frame_err, 1);
        check("t3_perr", parity_err, 0);
        consume("t3");

        // 4: overrun while the consumer stalls
        send_frame(8'h11, 1'b0, 1'b1, 0);
        tick();
        check("t4_first", data_out, 8'h11);
        send_frame(8'h22, 1'b0, 1'b1, 0);
        tick();
        check("t4_hold",    data_out,   8'h11);
        check("t4_valid",   data_valid, 1);
        check("t4_overrun", overrun,    1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("t4_ovr_clr", overrun,    0);
        check("t4_drained", data_valid, 0);

        // 5: reset mid-frame with an unread errored word pending
        send_frame(8'h96, 1'b1, 1'b0, 0);
        tick();
        check("t5_pending", data_valid, 1);
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1, 0);
        end
        check("t5_busy_mid", busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("t5_rst");
        tick();
        rst = 1'b0;
        tick();
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        tick();
        check("t5_valid", data_valid, 1);
        check("t5_data",  data_out,   8'h5A);
        check("t5_perr",  parity_err, 0);
        check("t5_ferr",  frame_err,  0);
        consume("t5");

        // 6: sparse strobes, one every 4th clock
        send_frame(8'hFF, 1'b0, 1'b1, 3);
        check("t6_latency", data_valid, 0);
        tick();
        check("t6_valid", data_valid, 1);
        check("t6_data",  data_out,   8'hFF);
        check("t6_perr",  parity_err, 0);
        consume("t6");

        // Randomized stream with an always-ready consumer: every frame must come out in order.
        data_ready = 1'b1;
        sb_on      = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r_data = W'($urandom);
            r_par  = 1'($urandom_range(0, 1));
            r_stop = ($urandom_range(0, 3) != 0);
            r_gap  = $urandom_range(0, 3);
            r_idle = $urandom_range(0, 2);
            repeat (r_idle) send_bit(1'b1, r_gap);
            exp_q.push_back('{data: r_data, perr: exp_perr(r_data, r_par), ferr: ~r_stop});
            send_frame(r_data, r_par, r_stop, r_gap);
        end
        repeat (4) tick();
        sb_on = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_overrun", overrun, 0);
        check("rand_busy",    busy,    0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
